c1s2_issue_sched: RTL and testbench
===================================

# c1s2_issue_sched

Issue scheduler for the C1S2 convolution/pool datapath. On a start pulse it walks every 2x2 pooling window of the convolution output. Inside each window it walks the four conv anchors, and for each anchor it walks all kernels, issuing one token per (anchor, kernel) pair. Each token carries the anchor address, the kernel/bias index, the pool sub-position, a pool-last flag and the pooled write address. The tokens feed the address generator, the kernel/bias ROMs and the pool-buffer logic through a valid/ready handshake, so a stalling datapath back-pressures the walk.

## Interface
- IMG_W, 32: padded input image row pitch, in words
- CONV_W, 28: conv output width (even)
- CONV_H, 28: conv output height (even)
- KERNEL_NUM, 6: number of kernels/biases
- ANCHOR_BASE, 0: offset added to every anchor address
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE without done
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last token handshake
- iss_valid  out  1  token valid
- iss_ready  in  1  datapath accepts token
- iss_anchor  out  32  top-left read anchor of the 5x5 window
- iss_kernel  out  8  kernel/bias ROM index
- iss_sub  out  2  pool sub-position {dy,dx}
- iss_pool_last  out  1  high when iss_sub==3 (pool window complete for this kernel)
- iss_wr_addr  out  32  pooled output address
- stall_cnt  out  32  stall counter (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE on handshake of the last token.
  - RUN→IDLE on abort.
  - DONE→IDLE unconditionally after one cycle.
- Loop order, outermost first: pr 0..CONV_H/2-1, pc 0..CONV_W/2-1, sub 0..3, k 0..KERNEL_NUM-1.
- A handshake is iss_valid & iss_ready. It advances k; wrap of k advances sub, and so on up the loop nest.
- Field computation (registered):
  - dy = sub[1], dx = sub[0].
  - iss_anchor = ANCHOR_BASE + (2*pr+dy)*IMG_W + (2*pc+dx).
  - iss_wr_addr = k*(CONV_W/2)*(CONV_H/2) + pr*(CONV_W/2) + pc.
  - All arithmetic is unsigned 32-bit; no saturation.
- Total tokens per run: 4*KERNEL_NUM*(CONV_W/2)*(CONV_H/2); 4704 at defaults.
- All token fields are stable while iss_valid=1 and iss_ready=0.
- start while busy or in DONE is ignored.
- abort takes priority over a same-cycle handshake: the token is considered not issued, and done does not pulse.
- Reset mid-run: state returns to IDLE asynchronously; all counters clear.

## Timing
- Reset values:
  - done=0, busy=0, iss_valid=0, stall_cnt=0.
  - All token fields 0; loop counters 0; state IDLE.
- Start in cycle t: busy=1 and iss_valid=1 from cycle t+1, presenting token 0.
- With iss_ready held high, one token per cycle; no bubbles between tokens, including across window wraps.
- Last handshake in cycle n:
  - cycle n+1: iss_valid=0, busy=0, done=1, state DONE.
  - cycle n+2: IDLE; a new start is accepted from cycle n+2.
- Abort in cycle a: iss_valid=0 and busy=0 from cycle a+1; done stays 0.
- iss_ready is ignored when iss_valid=0.

## Configuration
- C1S2_SCHED_STALL_CNT_EN defined:
  - stall_cnt counts cycles in RUN with iss_valid & !iss_ready.
  - Cleared on an accepted start; holds its value after done/abort; wraps at 2^32.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Reset, then start with iss_ready=1:
  - token 0: anchor 0, kernel 0, sub 0, wr 0.
  - token 6: anchor 1, kernel 0, sub 1.
  - token 18: anchor 33, sub 3, pool_last=1, wr 0.
  - token 23: kernel 5, wr 980.
- Full run, ready=1: exactly 4704 handshakes.
  - Final token: anchor 891, kernel 5, wr 1175.
  - done pulses 1 cycle later; busy drops in the same cycle.
- Random iss_ready at 50%: token stream is identical to the ready=1 run.
  - Fields hold during stalls.
  - With C1S2_SCHED_STALL_CNT_EN defined, stall_cnt equals the number of stalled cycles.
- Window wrap, ready=1: token 24 (pc=1) has anchor 2, wr 1.
  - Token 24*14=336 (pr=1, pc=0) has anchor 64, wr 14.
- abort asserted on the same cycle as a handshake at token 100:
  - iss_valid=0 next cycle; no done.
  - A following start restarts at token 0.
- start pulse during RUN and during DONE: ignored.
  - rst_n asserted mid-run → all outputs 0 immediately, no done.

Source files
------------

// File: rtl/c1s2_issue_sched.sv
// Issue scheduler for the C1S2 conv/pool datapath: walks pool windows, conv anchors and kernels.
// Optional stall counter built when C1S2_SCHED_STALL_CNT_EN is defined.
module c1s2_issue_sched #(
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned CONV_W      = 28,
  parameter int unsigned CONV_H      = 28,
  parameter int unsigned KERNEL_NUM  = 6,
  parameter int unsigned ANCHOR_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_anchor,
  output logic [7:0]  iss_kernel,
  output logic [1:0]  iss_sub,
  output logic        iss_pool_last,
  output logic [31:0] iss_wr_addr,
  output logic [31:0] stall_cnt
);

  localparam int unsigned PW    = CONV_W / 2;
  localparam int unsigned PH    = CONV_H / 2;
  localparam int unsigned PLANE = PW * PH;
  localparam int unsigned CW    = 16;
  localparam int unsigned KW    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] pr_q, pr_d, pc_q, pc_d;
  logic [1:0]    sub_q, sub_d;
  logic [KW-1:0] k_q, k_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   anchor_q, anchor_d;
  logic [31:0]   wr_q, wr_d;
  logic [7:0]    kern_q, kern_d;
  logic [1:0]    isub_q, isub_d;
  logic          plast_q, plast_d;
  logic          hs_c, last_c;

  assign hs_c   = valid_q & iss_ready;
  assign last_c = (pr_q == CW'(PH - 1)) && (pc_q == CW'(PW - 1)) &&
                  (sub_q == 2'd3) && (k_q == KW'(KERNEL_NUM - 1));

  // Next state and loop-nest advance; abort wins over a same-cycle handshake
  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    sub_d   = sub_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          pr_d    = '0;
          pc_d    = '0;
          sub_d   = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          pr_d    = '0;
          pc_d    = '0;
          sub_d   = '0;
          k_d     = '0;
        end else if (hs_c) begin
          if (last_c) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pr_d    = '0;
            pc_d    = '0;
            sub_d   = '0;
            k_d     = '0;
          end else if (k_q != KW'(KERNEL_NUM - 1)) begin
            k_d = k_q + KW'(1);
          end else begin
            k_d = '0;
            if (sub_q != 2'd3) begin
              sub_d = sub_q + 2'd1;
            end else begin
              sub_d = '0;
              if (pc_q != CW'(PW - 1)) begin
                pc_d = pc_q + CW'(1);
              end else begin
                pc_d = '0;
                pr_d = pr_q + CW'(1);
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Token fields follow the next loop position so they are registered alongside valid
  always_comb begin
    anchor_d = 32'(ANCHOR_BASE)
             + (32'(pr_d) * 32'd2 + 32'(sub_d[1])) * 32'(IMG_W)
             + 32'(pc_d) * 32'd2 + 32'(sub_d[0]);
    wr_d     = 32'(k_d) * 32'(PLANE) + 32'(pr_d) * 32'(PW) + 32'(pc_d);
    kern_d   = 8'(k_d);
    isub_d   = sub_d;
    plast_d  = (sub_d == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pr_q     <= '0;
      pc_q     <= '0;
      sub_q    <= '0;
      k_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      anchor_q <= '0;
      wr_q     <= '0;
      kern_q   <= '0;
      isub_q   <= '0;
      plast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
      sub_q    <= sub_d;
      k_q      <= k_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      anchor_q <= anchor_d;
      wr_q     <= wr_d;
      kern_q   <= kern_d;
      isub_q   <= isub_d;
      plast_q  <= plast_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign iss_valid     = valid_q;
  assign iss_anchor    = anchor_q;
  assign iss_kernel    = kern_q;
  assign iss_sub       = isub_q;
  assign iss_pool_last = plast_q;
  assign iss_wr_addr   = wr_q;

`ifdef C1S2_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts back-pressured cycles of the current/last run
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_RUN && valid_q && !iss_ready) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_c1s2_issue_sched.sv
// Self-checking bench for c1s2_issue_sched: token scoreboard, field vector table, abort/reset/start corners.
module tb_c1s2_issue_sched;

  localparam int TOTAL = 4704;

  typedef struct packed {
    logic [31:0] anchor;
    logic [7:0]  kernel;
    logic [1:0]  sub;
    logic        pl;
    logic [31:0] wr;
  } tok_t;

  typedef struct {
    int   idx;
    tok_t t;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, iss_ready;
  logic        busy, done, iss_valid, iss_pool_last;
  logic [31:0] iss_anchor, iss_wr_addr, stall_cnt;
  logic [7:0]  iss_kernel;
  logic [1:0]  iss_sub;

  int   errs = 0;
  int   checks = 0;
  tok_t exp_q[$];
  tok_t got[TOTAL];
  vec_t vecs[8];

  always #5 clk = ~clk;

  c1s2_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_anchor(iss_anchor), .iss_kernel(iss_kernel), .iss_sub(iss_sub),
    .iss_pool_last(iss_pool_last), .iss_wr_addr(iss_wr_addr), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic tok_t cur_tok();
    return {iss_anchor, iss_kernel, iss_sub, iss_pool_last, iss_wr_addr};
  endfunction

  // Reference walk: window rows/cols, then sub-position, then kernel
  task automatic push_expected();
    exp_q.delete();
    for (int pr = 0; pr < 14; pr++)
      for (int pc = 0; pc < 14; pc++)
        for (int s = 0; s < 4; s++)
          for (int k = 0; k < 6; k++) begin
            tok_t t;
            t.anchor = 32'((2 * pr + s / 2) * 32 + 2 * pc + s % 2);
            t.kernel = 8'(k);
            t.sub    = 2'(s);
            t.pl     = (s == 3);
            t.wr     = 32'(k * 196 + pr * 14 + pc);
            exp_q.push_back(t);
          end
  endtask

  task automatic run(input int pct, input int abort_tok, input int inj_start_tok,
                     input bit start_in_done, input bit keep);
    int ntok = 0;
    int cyc = 0;
    int stalls = 0;
    bit hs, ab;
    tok_t cur;
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 96'(busy), 96'd1);
    chk("start_valid", 96'(iss_valid), 96'd1);
    while (cyc < 30000) begin
      hs = 1'b0;
      ab = 1'b0;
      if (iss_valid) begin
        cur = cur_tok();
        if (exp_q.size() == 0) chk("extra_token", 96'(cur), 96'd0);
        else chk("token", 96'(cur), 96'(exp_q[0]));
        iss_ready = ($urandom_range(99) < 32'(pct));
        if (ntok == abort_tok) begin
          iss_ready = 1'b1;
          abort = 1'b1;
          ab = 1'b1;
        end
        if (ntok == inj_start_tok) start = 1'b1;
        hs = iss_ready && !ab;
        if (!iss_ready) stalls++;
        if (hs && keep) got[ntok] = cur;
      end else begin
        chk("valid_in_run", 96'(iss_valid), 96'd1);
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (ab) begin
        chk("abort_valid", 96'(iss_valid), 96'd0);
        chk("abort_busy", 96'(busy), 96'd0);
        repeat (3) begin
          chk("abort_no_done", 96'(done), 96'd0);
          @(posedge clk); #1;
        end
        return;
      end
      if (hs) begin
        void'(exp_q.pop_front());
        ntok++;
      end
      if (ntok == TOTAL) break;
      chk("early_done", 96'(done), 96'd0);
    end
    chk("token_count", 96'(ntok), 96'(TOTAL));
    if (pct == 100) chk("no_bubbles", 96'(cyc), 96'(TOTAL));
    chk("end_done", 96'(done), 96'd1);
    chk("end_busy", 96'(busy), 96'd0);
    chk("end_valid", 96'(iss_valid), 96'd0);
`ifdef C1S2_SCHED_STALL_CNT_EN
    chk("stall_cnt", 96'(stall_cnt), 96'(stalls));
`else
    chk("stall_cnt", 96'(stall_cnt), 96'd0);
`endif
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_len", 96'(done), 96'd0);
    chk("idle_after_done_busy", 96'(busy), 96'd0);
    chk("idle_after_done_valid", 96'(iss_valid), 96'd0);
    @(posedge clk); #1;
    chk("still_idle", 96'(busy), 96'd0);
  endtask

  initial begin
    vecs[0] = '{0,    '{32'd0,   8'd0, 2'd0, 1'b0, 32'd0}};
    vecs[1] = '{1,    '{32'd0,   8'd1, 2'd0, 1'b0, 32'd196}};
    vecs[2] = '{6,    '{32'd1,   8'd0, 2'd1, 1'b0, 32'd0}};
    vecs[3] = '{18,   '{32'd33,  8'd0, 2'd3, 1'b1, 32'd0}};
    vecs[4] = '{23,   '{32'd33,  8'd5, 2'd3, 1'b1, 32'd980}};
    vecs[5] = '{24,   '{32'd2,   8'd0, 2'd0, 1'b0, 32'd1}};
    vecs[6] = '{336,  '{32'd64,  8'd0, 2'd0, 1'b0, 32'd14}};
    vecs[7] = '{4703, '{32'd891, 8'd5, 2'd3, 1'b1, 32'd1175}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; iss_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_valid", 96'(iss_valid), 96'd0);
    chk("rst_stall", 96'(stall_cnt), 96'd0);
    chk("rst_fields", 96'(cur_tok()), 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full run with ready held high, start injected mid-run and during DONE
    run(100, -1, 50, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec_tok%0d", vecs[i].idx), 96'(got[vecs[i].idx]), 96'(vecs[i].t));

    // Back-pressured run must produce the same stream
    run(50, -1, -1, 1'b0, 1'b0);

    // Abort on the cycle token 100 is handshaken, then a clean restart
    run(100, 100, -1, 1'b0, 1'b0);
    run(100, -1, -1, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    iss_ready = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 96'(iss_valid), 96'd0);
    chk("mrst_busy", 96'(busy), 96'd0);
    chk("mrst_done", 96'(done), 96'd0);
    chk("mrst_fields", 96'(cur_tok()), 96'd0);
    chk("mrst_stall", 96'(stall_cnt), 96'd0);
    @(posedge clk); #1;
    chk("mrst_no_done", 96'(done), 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(70, -1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
